// File: rtl/div16s_iterative.sv
// Iterative restoring divider: one quotient bit per cycle through a WIDTH+1-bit subtractor.
// Optional unsigned mode (signed_op port) when DIV_UNSIGNED_OP_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one restoring step per cycle, counter runs WIDTH-1 down to 0
// DONE  | result presented, out_valid high until out_ready
module div16s_iterative #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_OP_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             op_signed;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             is_zero, is_ovf;
    logic [WIDTH:0]   shifted, trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_step, q_step, quo_fix, rem_fix;

`ifdef DIV_UNSIGNED_OP_EN
    assign op_signed = signed_op;
`else
    assign op_signed = 1'b1;
`endif

    // Operand preparation: magnitudes and special-case detection at accept time.
    always_comb begin
        dvd_neg = op_signed & dividend[WIDTH-1];
        dvs_neg = op_signed & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
        is_zero = (divisor == '0);
        is_ovf  = op_signed && (dividend == MOST_NEG) && (divisor == '1);
    end

    // Single restoring step; the final step's result is sign-fixed in the same cycle.
    always_comb begin
        shifted  = {rem_q, qsh_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvsr_q};
        trial_ok = ~trial[WIDTH];
        rem_step = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_step   = {qsh_q[WIDTH-2:0], trial_ok};
        quo_fix  = sgn_quo_q ? (~q_step + 1'b1) : q_step;
        rem_fix  = sgn_rem_q ? (~rem_step + 1'b1) : rem_step;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        qsh_d       = qsh_q;
        dvsr_d      = dvsr_q;
        sgn_quo_d   = sgn_quo_q;
        sgn_rem_d   = sgn_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgn_quo_d = dvd_neg ^ dvs_neg;
                    sgn_rem_d = dvd_neg;
                    dvsr_d    = dvs_mag;
                    if (is_zero) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        state_d     = DONE;
                    end else if (is_ovf) begin
                        quotient_d  = dividend;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = '0;
                        qsh_d   = dvd_mag;
                        cnt_d   = CNT_LAST;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                qsh_d = q_step;
                if (cnt_q == '0) begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            qsh_q       <= '0;
            dvsr_q      <= '0;
            sgn_quo_q   <= 1'b0;
            sgn_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            qsh_q       <= qsh_d;
            dvsr_q      <= dvsr_d;
            sgn_quo_q   <= sgn_quo_d;
            sgn_rem_q   <= sgn_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Handshake outputs depend only on state, never on in_valid/out_ready.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div16s_iterative.sv
// Scoreboard bench for div16s_iterative: driver pushes reference results, monitor pops on output transfers.
module tb_div16s_iterative;

    localparam int W = 16;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    always #5 clk = ~clk;

    div16s_iterative #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_UNSIGNED_OP_EN
        .signed_op   (signed_op),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    // Reference: plain integer division, which truncates toward zero.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        exp_t e;
        int   sa, sd, qi, ri;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sgn && a == MIN_NEG && b == '1) begin
            e.q   = a;
            e.r   = '0;
            e.ovf = 1'b1;
        end else if (sgn) begin
            sa  = int'($signed(a));
            sd  = int'($signed(b));
            qi  = sa / sd;
            ri  = sa - qi * sd;
            e.q = qi[W-1:0];
            e.r = ri[W-1:0];
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result actual q=%0h r=%0h required=no result", quotient, remainder);
            end else begin
                e = sb.pop_front();
                if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
                    errors++;
                    $display("FAIL result actual q=%0h r=%0h dbz=%0b ovf=%0b required q=%0h r=%0h dbz=%0b ovf=%0b",
                             quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("issue_ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        dividend  = a;
        divisor   = b;
        signed_op = sgn;
        in_valid  = 1'b1;
        sb.push_back(model(a, b, sgn));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; also notes whether in_ready stayed low.
    task automatic wait_valid(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", sb.size(), 32'd0);
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input int lat_req);
        int lat;
        bit busy_ok;
        issue(a, b, 1'b1);
        wait_valid(lat, busy_ok);
        chk({name, "_latency"}, lat, lat_req);
        chk({name, "_in_ready_busy"}, {31'b0, busy_ok}, 32'd1);
        drain();
    endtask

    initial begin
        int lat;
        bit busy_ok;
        logic [W-1:0] a, b;
        bit sgn;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("reset_ovf", {31'b0, overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(W'(100), W'(7), 1'b1);
        wait_valid(lat, busy_ok);
        chk("p100_7_latency", lat, W);
        chk("p100_7_in_ready_busy", {31'b0, busy_ok}, 32'd1);
        chk("p100_7_quotient", quotient, 32'h000E);
        chk("p100_7_remainder", remainder, 32'h0002);
        drain();

        directed("m100_7", W'(-100), W'(7), W);
        directed("p100_m7", W'(100), W'(-7), W);
        // Special cases resolve on the accept edge itself.
        directed("div_zero", W'(5), W'(0), 0);
        directed("min_by_m1", MIN_NEG, W'(-1), 0);
        directed("zero_div", W'(0), W'(9), W);
        directed("min_by_1", MIN_NEG, W'(1), W);

        out_ready = 1'b0;
        issue(W'(1000), W'(3), 1'b1);
        wait_valid(lat, busy_ok);
        chk("bp_latency", lat, W);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid_hold", {31'b0, out_valid}, 32'd1);
            chk("bp_quotient_hold", quotient, 32'd333);
            chk("bp_remainder_hold", remainder, 32'd1);
            chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
        chk("bp_out_valid_after", {31'b0, out_valid}, 32'd0);
        chk("bp_quotient_kept", quotient, 32'd333);
        chk("bp_pending", sb.size(), 32'd0);

        issue(W'(30000), W'(7), 1'b1);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("midrst_ovf", {31'b0, overflow}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(W'(32767), W'(1), 1'b1);
        wait_valid(lat, busy_ok);
        chk("post_rst_latency", lat, W);
        chk("post_rst_quotient", quotient, 32'd32767);
        chk("post_rst_remainder", remainder, 32'd0);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
            sgn = 1'b1;
`ifdef DIV_UNSIGNED_OP_EN
            sgn = ($urandom_range(0, 1) == 1);
`endif
            if (b == '0) b = W'(1);
            if (sgn && a == MIN_NEG && b == '1) b = W'(2);
            issue(a, b, sgn);
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
